// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_drain_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage : fifo_rd_drain_pkg

// File: rtl/fifo_skid_buf2.sv
// Two-entry register FIFO; entry 0 is always the head, so data_out is a flop.
module fifo_skid_buf2
  import fifo_rd_drain_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      ent0;
  logic [WIDTH-1:0]      ent1;
  logic [SKID_CNT_W-1:0] cnt;
  logic                  do_pop;
  logic                  do_push;

  // Pops on an empty buffer and pushes into a full, non-popping buffer are dropped.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != SKID_CNT_W'(SKID_DEPTH)) || do_pop);

  // Shift-style storage: popping moves entry 1 into the head slot.
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else if (clr) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (cnt == SKID_CNT_W'(1)) begin
            ent0 <= data_in;
          end else begin
            ent0 <= ent1;
            ent1 <= data_in;
          end
        end
        2'b10: begin
          if (cnt == '0) ent0 <= data_in;
          else           ent1 <= data_in;
          cnt <= cnt + SKID_CNT_W'(1);
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - SKID_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_out = ent0;
  assign count    = cnt;

endmodule : fifo_skid_buf2

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pulls a burst of words from the async FIFO read port
// and re-presents them as a valid/ready stream through a 2-entry skid buffer.
// Optional statistics outputs (uf_cnt, word_cnt) under FIFO_RD_DRAIN_STATS_EN.
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  input  logic             empty,
  input  logic             underflow,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             uf_err
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [15:0]      uf_cnt,
  output logic [31:0]      word_cnt
`endif
);

  drain_state_e          state;
  logic [LEN_W-1:0]      issue_cnt;
  logic [LEN_W-1:0]      deliv_cnt;
  logic                  inflight;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic                  buf_clr;
  logic                  hs;
  logic [2:0]            occ;

  // Stream side: words are only offered while running; FLUSH hides the buffer.
  assign m_valid = (buf_cnt != '0) && (state == RUN);
  assign hs      = m_valid && m_ready;
  assign busy    = (state != IDLE);

  // Occupancy after this cycle's pop, plus the word already requested from the FIFO.
  assign occ = 3'(buf_cnt) + 3'(inflight) - 3'(hs);

  // FIFO read request; the slot freed by a same-cycle pop keeps 1 word/cycle.
  assign rd_en = (state == RUN) && !abort && !empty &&
                 (issue_cnt != '0) && (occ < 3'd2);

  // Discard buffered words once nothing is left in flight.
  assign buf_clr = (state == FLUSH) && !inflight;

  fifo_skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .clr      (buf_clr),
    .push     (inflight),
    .pop      (hs),
    .data_in  (rdata),
    .data_out (m_data),
    .count    (buf_cnt)
  );

  // Burst FSM, issue/delivery counters, completion pulses and sticky underflow flag.
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      deliv_cnt <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      uf_err    <= 1'b0;
    end else begin
      inflight <= rd_en;
      done     <= 1'b0;
      aborted  <= 1'b0;
      if (rd_en) issue_cnt <= issue_cnt - LEN_W'(1);
      if (hs && (deliv_cnt != '0)) deliv_cnt <= deliv_cnt - LEN_W'(1);
      if ((state != IDLE) && underflow) uf_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            issue_cnt <= burst_len;
            deliv_cnt <= burst_len;
            uf_err    <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= FLUSH;
          end else if ((deliv_cnt == '0) || (hs && (deliv_cnt == LEN_W'(1)))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          if (!inflight) begin
            state     <= IDLE;
            done      <= 1'b1;
            aborted   <= 1'b1;
            issue_cnt <= '0;
            deliv_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  // Saturating underflow-cycle counter and free-running handshake counter.
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      uf_cnt   <= '0;
      word_cnt <= '0;
    end else begin
      if ((state != IDLE) && underflow && (uf_cnt != 16'hFFFF)) uf_cnt <= uf_cnt + 16'd1;
      if (hs) word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule : fifo_rd_drain
